sap_core_param: RTL and testbench

//  Parametrised successor to the SAP-1 top level: a complete single-bus CPU core with a writable

---
 rtl/sap_core_param_if.sv | 28 ++
 rtl/sap_core_param.sv | 190 +++++++++++++++++++
 tb/tb_sap_core_param.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sap_core_param_if.sv
// Control, programming and observation signals of the SAP core.
// The master side drives run and the programming port; the slave side is the core.
interface sap_core_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              run;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_wdata;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              halted;
    logic              flag_c;
    logic              flag_z;
    logic [ADDR_W-1:0] pc_dbg;
    logic [DATA_W-1:0] bus_dbg;

    modport master (
        output run, prog_we, prog_addr, prog_wdata,
        input  out, out_valid, halted, flag_c, flag_z, pc_dbg, bus_dbg
    );

    modport slave (
        input  run, prog_we, prog_addr, prog_wdata,
        output out, out_valid, halted, flag_c, flag_z, pc_dbg, bus_dbg
    );
endinterface

// File: rtl/sap_core_param.sv
// Parametrised SAP single-bus CPU core: RAM, fetch/execute FSM, carry/zero flags, jumps.
// The RAM is loaded through the programming port while stopped or halted.
module sap_core_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4  // must equal DATA_W-4
) (
    input logic               clk,
    input logic               low_clr,
    sap_core_param_if.slave   bus_if
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpSta = 4'h4;
    localparam logic [3:0] OpLdi = 4'h5;
    localparam logic [3:0] OpJmp = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpOut = 4'h9;
    localparam logic [3:0] OpHlt = 4'hF;

    typedef enum logic [2:0] {StT0, StT1, StT2, StT3, StT4, StHalt} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              c_q, c_d;
    logic              z_q, z_d;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] operand_ext;
    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   alu_sum;
    logic [3:0]        opcode;
    logic              is_sub;
    logic              cpu_we;
    logic              prog_ok;

    assign opcode      = ir_q[DATA_W-1 -: 4];
    assign operand_ext = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
    assign pc_ext      = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    assign ram_rd      = mem_q[mar_q];
    assign is_sub      = (opcode == OpSub);
    assign alu_b       = is_sub ? ~b_q : b_q;
    assign alu_sum     = {1'b0, a_q} + {1'b0, alu_b} + {{DATA_W{1'b0}}, is_sub};
    assign prog_ok     = bus_if.prog_we && (!bus_if.run || state_q == StHalt);

    // Single shared bus: whichever source the current T-state selects, otherwise 0.
    always_comb begin
        bus = '0;
        case (state_q)
            StT0: bus = pc_ext;
            StT1: bus = ram_rd;
            StT2: begin
                case (opcode)
                    OpLda, OpAdd, OpSub, OpSta, OpLdi, OpJmp, OpJc, OpJz: bus = operand_ext;
                    OpOut:                                                bus = a_q;
                    default:                                              bus = '0;
                endcase
            end
            StT3: begin
                case (opcode)
                    OpLda, OpAdd, OpSub: bus = ram_rd;
                    OpSta:               bus = a_q;
                    default:             bus = '0;
                endcase
            end
            StT4:    bus = alu_sum[DATA_W-1:0];
            default: bus = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        c_d         = c_q;
        z_d         = z_q;
        out_valid_d = 1'b0;
        cpu_we      = 1'b0;
        if (bus_if.run) begin
            case (state_q)
                StT0: begin
                    mar_d   = bus[ADDR_W-1:0];
                    state_d = StT1;
                end
                StT1: begin
                    ir_d    = bus;
                    pc_d    = pc_q + 1'b1;
                    state_d = StT2;
                end
                StT2: begin
                    state_d = StT0;
                    case (opcode)
                        OpLda, OpAdd, OpSub, OpSta: begin
                            mar_d   = bus[ADDR_W-1:0];
                            state_d = StT3;
                        end
                        OpLdi: a_d = bus;
                        OpJmp: pc_d = bus[ADDR_W-1:0];
                        OpJc:  if (c_q) pc_d = bus[ADDR_W-1:0];
                        OpJz:  if (z_q) pc_d = bus[ADDR_W-1:0];
                        OpOut: begin
                            out_d       = bus;
                            out_valid_d = 1'b1;
                        end
                        OpHlt:   state_d = StHalt;
                        default: state_d = StT0;
                    endcase
                end
                StT3: begin
                    state_d = StT0;
                    case (opcode)
                        OpLda: a_d = bus;
                        OpAdd, OpSub: begin
                            b_d     = bus;
                            state_d = StT4;
                        end
                        OpSta:   cpu_we = 1'b1;
                        default: state_d = StT0;
                    endcase
                end
                StT4: begin
                    a_d     = bus;
                    c_d     = alu_sum[DATA_W];
                    z_d     = (alu_sum[DATA_W-1:0] == '0);
                    state_d = StT0;
                end
                default: state_d = StHalt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge low_clr) begin
        if (!low_clr) begin
            state_q     <= StT0;
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            z_q         <= z_d;
        end
    end

    // RAM survives reset; a core store is suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (cpu_we && low_clr) begin
            mem_q[mar_q] <= bus;
        end else if (prog_ok) begin
            mem_q[bus_if.prog_addr] <= bus_if.prog_wdata;
        end
    end

    assign bus_if.out       = out_q;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.halted    = (state_q == StHalt);
    assign bus_if.flag_c    = c_q;
    assign bus_if.flag_z    = z_q;
    assign bus_if.pc_dbg    = pc_q;
    assign bus_if.bus_dbg   = bus;
endmodule

// File: tb/tb_sap_core_param.sv
// Directed bench for sap_core_param: expected OUT values are queued when a program is
// loaded and popped whenever out_valid is seen.
module tb_sap_core_param;
    logic clk;
    logic low_clr;

    sap_core_param_if #(.DATA_W(8), .ADDR_W(4)) dut_if ();

    sap_core_param #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk     (clk),
        .low_clr (low_clr),
        .bus_if  (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors;
    int         checks;
    int         pulses;
    int         cyc;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, sampled 1 time unit later; consumes scoreboard entries on out_valid.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (dut_if.out_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {31'd0, dut_if.out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", {24'd0, dut_if.out}, {24'd0, e});
            end
        end
    endtask

    task automatic load(input int addr, input logic [7:0] data);
        dut_if.prog_we    = 1'b1;
        dut_if.prog_addr  = addr[3:0];
        dut_if.prog_wdata = data;
        tick();
        dut_if.prog_we    = 1'b0;
    endtask

    task automatic do_reset();
        dut_if.run = 1'b0;
        low_clr    = 1'b0;
        repeat (2) tick();
        low_clr    = 1'b1;
        tick();
        pulses     = 0;
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        dut_if.run = 1'b1;
        cycles = 0;
        while (dut_if.halted !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        check("halted", {31'd0, dut_if.halted}, 32'd1);
        dut_if.run = 1'b0;
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        pulses            = 0;
        low_clr           = 1'b0;
        dut_if.run        = 1'b0;
        dut_if.prog_we    = 1'b0;
        dut_if.prog_addr  = '0;
        dut_if.prog_wdata = '0;
        #3;
        check("rst_out", {24'd0, dut_if.out}, 32'd0);
        check("rst_out_valid", {31'd0, dut_if.out_valid}, 32'd0);
        check("rst_halted", {31'd0, dut_if.halted}, 32'd0);
        check("rst_flags", {30'd0, dut_if.flag_c, dut_if.flag_z}, 32'd0);
        check("rst_pc", {28'd0, dut_if.pc_dbg}, 32'd0);
        do_reset();

        // LDA 14; ADD 15; OUT; HLT with 05 + 03
        load(0, 8'h1E); load(1, 8'h2F); load(2, 8'h90); load(3, 8'hF0);
        load(14, 8'h05); load(15, 8'h03);
        exp_q.push_back(8'h08);
        run_to_halt(100, cyc);
        check("t1_cycles", cyc, 32'd15);
        check("t1_pulses", pulses, 32'd1);
        check("t1_out", {24'd0, dut_if.out}, 32'h08);
        check("t1_flags", {30'd0, dut_if.flag_c, dut_if.flag_z}, 32'd0);

        // FF + 01 wraps to zero with carry
        do_reset();
        load(14, 8'hFF); load(15, 8'h01);
        exp_q.push_back(8'h00);
        run_to_halt(100, cyc);
        check("t2_out", {24'd0, dut_if.out}, 32'h00);
        check("t2_flags", {30'd0, dut_if.flag_c, dut_if.flag_z}, 32'd3);
        check("t2_pulses", pulses, 32'd1);

        // LDI 7; SUB 15; JZ 5; OUT; HLT; HLT -- branch skips OUT and the HLT at 4
        do_reset();
        load(0, 8'h57); load(1, 8'h3F); load(2, 8'h85); load(3, 8'h90);
        load(4, 8'hF0); load(5, 8'hF0); load(15, 8'h07);
        run_to_halt(100, cyc);
        check("t3_flags", {30'd0, dut_if.flag_c, dut_if.flag_z}, 32'd3);
        check("t3_pc", {28'd0, dut_if.pc_dbg}, 32'd6);
        check("t3_pulses", pulses, 32'd0);
        check("t3_cycles", cyc, 32'd14);

        // LDI 9; STA 13; LDI 0; LDA 13; OUT; HLT
        do_reset();
        load(0, 8'h59); load(1, 8'h4D); load(2, 8'h50); load(3, 8'h1D);
        load(4, 8'h90); load(5, 8'hF0);
        exp_q.push_back(8'h09);
        run_to_halt(100, cyc);
        check("t4_out", {24'd0, dut_if.out}, 32'h09);
        do_reset();
        load(0, 8'h1D); load(1, 8'h90); load(2, 8'hF0);
        exp_q.push_back(8'h09);
        run_to_halt(100, cyc);
        check("t4_ram13", {24'd0, dut_if.out}, 32'h09);
        check("t4_pulses", pulses, 32'd1);

        // Freeze at ADD T3; programming writes during run must be ignored
        do_reset();
        load(0, 8'h1E); load(1, 8'h2F); load(2, 8'h90); load(3, 8'hF0);
        load(14, 8'h05); load(15, 8'h03);
        exp_q.push_back(8'h08);
        dut_if.prog_we    = 1'b1;
        dut_if.prog_addr  = 4'd15;
        dut_if.prog_wdata = 8'h77;
        dut_if.run        = 1'b1;
        repeat (7) tick();
        dut_if.prog_we = 1'b0;
        dut_if.run     = 1'b0;
        check("t5_pc_t3", {28'd0, dut_if.pc_dbg}, 32'd2);
        check("t5_bus_t3", {24'd0, dut_if.bus_dbg}, 32'h03);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_pc_frozen", {28'd0, dut_if.pc_dbg}, 32'd2);
            check("t5_bus_frozen", {24'd0, dut_if.bus_dbg}, 32'h03);
        end
        run_to_halt(100, cyc);
        check("t5_resume_cycles", cyc, 32'd8);
        check("t5_out", {24'd0, dut_if.out}, 32'h08);
        check("t5_pulses", pulses, 32'd1);

        // Reset during STA T3: LDI 9; OUT; STA 12; HLT with ram[12]=33
        do_reset();
        load(12, 8'h33);
        load(0, 8'h59); load(1, 8'h90); load(2, 8'h4C); load(3, 8'hF0);
        exp_q.push_back(8'h09);
        dut_if.run = 1'b1;
        repeat (9) tick();
        low_clr = 1'b0;
        #1;
        check("t6_rst_out", {24'd0, dut_if.out}, 32'd0);
        check("t6_rst_valid", {31'd0, dut_if.out_valid}, 32'd0);
        check("t6_rst_halted", {31'd0, dut_if.halted}, 32'd0);
        check("t6_rst_flags", {30'd0, dut_if.flag_c, dut_if.flag_z}, 32'd0);
        check("t6_rst_pc", {28'd0, dut_if.pc_dbg}, 32'd0);
        check("t6_rst_bus", {24'd0, dut_if.bus_dbg}, 32'd0);
        tick();
        dut_if.run = 1'b0;
        tick();
        low_clr = 1'b1;
        pulses  = 0;
        load(0, 8'h1C); load(1, 8'h90); load(2, 8'hF0);
        exp_q.push_back(8'h33);
        dut_if.run = 1'b1;
        repeat (2) tick();
        check("t6_restart_pc", {28'd0, dut_if.pc_dbg}, 32'd1);
        run_to_halt(100, cyc);
        check("t6_ram12", {24'd0, dut_if.out}, 32'h33);
        check("t6_pulses", pulses, 32'd1);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
